// File: rtl/mc_txn_scheduler_pkg.sv
// mc_pkg: shared types and constants for the memory-controller transaction scheduler.
//   NTAGS / TAG_W  : tag count (and issue queue depth) and tag width
//   MC_AWIDTH/DWIDTH: default address / data widths of an issue entry
//   tag_state_t    : per-tag lifecycle
//   issue_entry_t  : one queued transaction {addr, data, rw, tag}
package mc_pkg;
    localparam int NTAGS     = 8;
    localparam int TAG_W     = 3;
    localparam int MC_AWIDTH = 32;
    localparam int MC_DWIDTH = 512;

    typedef logic [TAG_W-1:0] tag_t;

    typedef enum logic [1:0] {
        FREE      = 2'd0,
        QUEUED    = 2'd1,
        WAIT_DATA = 2'd2,
        RETURN    = 2'd3
    } tag_state_t;

    typedef struct packed {
        logic [MC_AWIDTH-1:0] addr;
        logic [MC_DWIDTH-1:0] data;
        logic                 rw;
        tag_t                 tag;
    } issue_entry_t;
endpackage

// File: rtl/mc_txn_scheduler_if.sv
// mc_txn_scheduler_if: all handshake/bus signals of the scheduler.
//   cache request : addr, data_tran, rw, valid_tran -> ack_tran, tag_tran, full
//   issue port    : issue_valid/issue_ready, issue_addr/data/rw/tag
//   completion    : cpl_valid/cpl_tag/cpl_data -> cpl_ready
//   read return   : read_data, tag_data, valid_data <- ack_data; protocol_err
// Modports: slave = scheduler view, master = cache/engine view.
import mc_pkg::*;

interface mc_txn_scheduler_if #(
    parameter int AWIDTH = MC_AWIDTH,
    parameter int DWIDTH = MC_DWIDTH
);
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data_tran;
    logic              rw;
    logic              valid_tran;
    logic              ack_tran;
    logic [TAG_W-1:0]  tag_tran;
    logic              full;
    logic              issue_valid;
    logic              issue_ready;
    logic [AWIDTH-1:0] issue_addr;
    logic [DWIDTH-1:0] issue_data;
    logic              issue_rw;
    logic [TAG_W-1:0]  issue_tag;
    logic              cpl_valid;
    logic [TAG_W-1:0]  cpl_tag;
    logic [DWIDTH-1:0] cpl_data;
    logic              cpl_ready;
    logic [DWIDTH-1:0] read_data;
    logic [TAG_W-1:0]  tag_data;
    logic              valid_data;
    logic              ack_data;
    logic              protocol_err;

    modport slave (
        input  addr, data_tran, rw, valid_tran, issue_ready,
               cpl_valid, cpl_tag, cpl_data, ack_data,
        output ack_tran, tag_tran, full, issue_valid, issue_addr, issue_data,
               issue_rw, issue_tag, cpl_ready, read_data, tag_data,
               valid_data, protocol_err
    );

    modport master (
        output addr, data_tran, rw, valid_tran, issue_ready,
               cpl_valid, cpl_tag, cpl_data, ack_data,
        input  ack_tran, tag_tran, full, issue_valid, issue_addr, issue_data,
               issue_rw, issue_tag, cpl_ready, read_data, tag_data,
               valid_data, protocol_err
    );
endinterface

// File: rtl/mc_tag_fifo.sv
// mc_tag_fifo: synchronous FIFO of issue entries, arrival order.
//   clock, reset (sync, active-low)
//   push/din   : write an entry (dropped if full and not popping)
//   pop/dout   : dout is the head; pop ignored when empty
//   empty/count: occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
import mc_pkg::*;

module mc_tag_fifo #(
    parameter int  DEPTH = NTAGS,
    parameter type T     = issue_entry_t,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              dout,
    output logic          empty,
    output logic [CW-1:0] count
);
    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mc_txn_scheduler.sv
// mc_txn_scheduler: DDR4 controller front end. Accepts cache transactions,
// allocates the lowest free tag, queues them in arrival order to the command
// engine, and returns read completions through a held valid/ack register.
//   clock, reset : single rising-edge clock, synchronous active-low reset
//   bus (slave)  : request, issue, completion and return signals
import mc_pkg::*;

module mc_txn_scheduler #(
    parameter int DWIDTH = MC_DWIDTH,
    parameter int AWIDTH = MC_AWIDTH
) (
    input  logic                clock,
    input  logic                reset,
    mc_txn_scheduler_if.slave   bus
);
    localparam int CNT_W = $clog2(NTAGS + 1);

    tag_state_t        state_q [NTAGS];
    tag_state_t        state_d [NTAGS];
    logic              ack_q;
    tag_t              tag_q;
    logic              full_q;
    logic              vd_q;
    logic              cr_q;
    logic              perr_q;
    logic [DWIDTH-1:0] rd_q;
    tag_t              rtag_q;

    issue_entry_t      push_entry;
    issue_entry_t      head;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_push;

    tag_t              free_tag;
    logic              any_free_d;
    logic              accept;
    logic              pop;
    logic              cpl_acc;
    logic              cpl_legal;
    logic              ret_ack;

    // ack_q blocks a second accept while the cache still holds the old request
    assign accept    = bus.valid_tran && !full_q && !ack_q;
    assign pop       = !fifo_empty && bus.issue_ready;
    assign cpl_acc   = bus.cpl_valid && cr_q;
    assign cpl_legal = (state_q[bus.cpl_tag] == WAIT_DATA);
    assign ret_ack   = bus.ack_data && vd_q;

    // Every queued entry owns a live tag, so occupancy never exceeds NTAGS;
    // the count check only keeps the FIFO self-protecting.
    assign fifo_push = accept && (fifo_count != CNT_W'(NTAGS));
    assign push_entry = '{addr: bus.addr, data: bus.data_tran,
                          rw: bus.rw, tag: free_tag};

    mc_tag_fifo #(.DEPTH(NTAGS), .T(issue_entry_t)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Lowest-numbered FREE tag from the pre-edge state; a tag freed at this
    // edge is therefore never reallocated at the same edge.
    always_comb begin
        free_tag = '0;
        for (int i = NTAGS - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) free_tag = tag_t'(i);
        end
    end

    // Each event targets a different state, so a tag sees at most one per edge.
    always_comb begin
        any_free_d = 1'b0;
        for (int i = 0; i < NTAGS; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                FREE:      if (accept && free_tag == tag_t'(i)) state_d[i] = QUEUED;
                QUEUED:    if (pop && head.tag == tag_t'(i))
                               state_d[i] = head.rw ? FREE : WAIT_DATA;
                WAIT_DATA: if (cpl_acc && bus.cpl_tag == tag_t'(i)) state_d[i] = RETURN;
                RETURN:    if (ret_ack && rtag_q == tag_t'(i)) state_d[i] = FREE;
                default:   ;
            endcase
            if (state_d[i] == FREE) any_free_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NTAGS; i++) state_q[i] <= FREE;
            ack_q  <= 1'b0;
            tag_q  <= '0;
            full_q <= 1'b0;
            vd_q   <= 1'b0;
            cr_q   <= 1'b1;
            perr_q <= 1'b0;
            rd_q   <= '0;
            rtag_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= accept;
            if (accept) tag_q <= free_tag;
            full_q  <= !any_free_d;
            // Illegal completions are swallowed; only the error pulse records them.
            perr_q  <= cpl_acc && !cpl_legal;
            if (cpl_acc && cpl_legal) begin
                vd_q   <= 1'b1;
                cr_q   <= 1'b0;
                rd_q   <= bus.cpl_data;
                rtag_q <= bus.cpl_tag;
            end else if (ret_ack) begin
                vd_q <= 1'b0;
                cr_q <= 1'b1;
            end
        end
    end

    assign bus.ack_tran     = ack_q;
    assign bus.tag_tran     = tag_q;
    assign bus.full         = full_q;
    assign bus.issue_valid  = !fifo_empty;
    // Head fields are zeroed while empty so stale storage never leaks out.
    assign bus.issue_addr   = fifo_empty ? '0 : head.addr;
    assign bus.issue_data   = fifo_empty ? '0 : head.data;
    assign bus.issue_rw     = fifo_empty ? 1'b0 : head.rw;
    assign bus.issue_tag    = fifo_empty ? '0 : head.tag;
    assign bus.cpl_ready    = cr_q;
    assign bus.read_data    = rd_q;
    assign bus.tag_data     = rtag_q;
    assign bus.valid_data   = vd_q;
    assign bus.protocol_err = perr_q;
endmodule

// File: tb/tb_mc_txn_scheduler.sv
module tb_mc_txn_scheduler;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mc_txn_scheduler_if #(.AWIDTH(32), .DWIDTH(512)) bus ();

    mc_txn_scheduler #(.DWIDTH(512), .AWIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    localparam logic [511:0] CDATA = {64{8'hA5}};
    localparam logic [511:0] WDATA = {16{32'h0BAD_CAFE}};
    localparam logic [511:0] D3    = {16{32'h3333_0003}};
    localparam logic [511:0] D1    = {16{32'h1111_0001}};

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic zero_inputs();
        bus.addr = '0; bus.data_tran = '0; bus.rw = 1'b0; bus.valid_tran = 1'b0;
        bus.issue_ready = 1'b0; bus.cpl_valid = 1'b0; bus.cpl_tag = '0;
        bus.cpl_data = '0; bus.ack_data = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"},   bus.ack_tran, 0);
        chk({tag, "_tagt"},  bus.tag_tran, 0);
        chk({tag, "_iv"},    bus.issue_valid, 0);
        chk({tag, "_iaddr"}, bus.issue_addr, 0);
        chk({tag, "_vd"},    bus.valid_data, 0);
        chk({tag, "_rdata"}, bus.read_data, 0);
        chk({tag, "_tdata"}, bus.tag_data, 0);
        chk({tag, "_perr"},  bus.protocol_err, 0);
        chk({tag, "_full"},  bus.full, 0);
        chk({tag, "_cr"},    bus.cpl_ready, 1);
    endtask

    task automatic do_reset();
        zero_inputs();
        reset = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        reset = 1'b1;
    endtask

    // Per-cycle vector: inputs applied before an edge, expected outputs after it.
    typedef struct {
        logic vt; logic rw; logic ir; logic cv; logic ad;
        logic [31:0] addr; logic [2:0] ct;
        logic e_ack; logic [2:0] e_tag; logic e_full; logic e_iv; logic e_irw;
        logic [2:0] e_itag; logic [31:0] e_iaddr; logic e_vd; logic [2:0] e_tdata; logic e_perr;
    } vec_t;
    vec_t vecs [13];

    // Random-phase reference model: tag ownership sets, arrival queue, return slot
    typedef struct { logic [31:0] addr; logic [511:0] data; logic rw; logic [2:0] tag; } ent_t;
    ent_t q[$];
    bit busy [8];
    bit waiting [8];
    bit m_ack, m_rv, m_perr;
    logic [2:0] m_ack_tag, m_rtag;
    logic [511:0] m_rdata;

    initial begin
        //            vt rw ir cv ad addr    ct | ack tag full iv irw itag iaddr   vd td perr
        vecs[0]  = '{1, 0, 0, 0, 0, 'h100, 0,  1,  0,  0,  1, 0,  0, 'h100, 0, 0, 0};
        vecs[1]  = '{0, 0, 1, 0, 0, 0,     0,  0,  0,  0,  0, 0,  0, 0,     0, 0, 0};
        vecs[2]  = '{0, 0, 0, 1, 0, 0,     0,  0,  0,  0,  0, 0,  0, 0,     1, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 1, 0,     0,  0,  0,  0,  0, 0,  0, 0,     0, 0, 0};
        vecs[4]  = '{1, 1, 1, 0, 0, 'h40,  0,  1,  0,  0,  1, 1,  0, 'h40,  0, 0, 0};
        vecs[5]  = '{0, 0, 1, 0, 0, 0,     0,  0,  0,  0,  0, 0,  0, 0,     0, 0, 0};
        vecs[6]  = '{1, 0, 0, 0, 0, 'h200, 0,  1,  0,  0,  1, 0,  0, 'h200, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 1, 0, 0,     5,  0,  0,  0,  1, 0,  0, 'h200, 0, 0, 1};
        vecs[8]  = '{0, 0, 0, 0, 0, 0,     0,  0,  0,  0,  1, 0,  0, 'h200, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 1, 0, 0,     0,  0,  0,  0,  1, 0,  0, 'h200, 0, 0, 1};
        vecs[10] = '{0, 0, 1, 0, 0, 0,     0,  0,  0,  0,  0, 0,  0, 0,     0, 0, 0};
        vecs[11] = '{0, 0, 0, 1, 0, 0,     0,  0,  0,  0,  0, 0,  0, 0,     1, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 1, 0,     0,  0,  0,  0,  0, 0,  0, 0,     0, 0, 0};

        zero_inputs();
        @(negedge clock);
        do_reset();

        // ---- table: single read, write freed at issue, tag reuse, illegal completions
        for (int r = 0; r < 13; r++) begin
            bus.valid_tran = vecs[r].vt; bus.rw = vecs[r].rw; bus.addr = vecs[r].addr;
            bus.data_tran = WDATA; bus.issue_ready = vecs[r].ir;
            bus.cpl_valid = vecs[r].cv; bus.cpl_tag = vecs[r].ct; bus.cpl_data = CDATA;
            bus.ack_data = vecs[r].ad;
            step();
            chk($sformatf("vec%0d_ack", r), bus.ack_tran, vecs[r].e_ack);
            if (vecs[r].e_ack) chk($sformatf("vec%0d_tag", r), bus.tag_tran, vecs[r].e_tag);
            chk($sformatf("vec%0d_full", r), bus.full, vecs[r].e_full);
            chk($sformatf("vec%0d_iv", r), bus.issue_valid, vecs[r].e_iv);
            if (vecs[r].e_iv) begin
                chk($sformatf("vec%0d_irw", r), bus.issue_rw, vecs[r].e_irw);
                chk($sformatf("vec%0d_itag", r), bus.issue_tag, vecs[r].e_itag);
                chk($sformatf("vec%0d_iaddr", r), bus.issue_addr, vecs[r].e_iaddr);
                if (vecs[r].e_irw) chk($sformatf("vec%0d_idata", r), bus.issue_data, WDATA);
            end
            chk($sformatf("vec%0d_vd", r), bus.valid_data, vecs[r].e_vd);
            chk($sformatf("vec%0d_cr", r), bus.cpl_ready, !vecs[r].e_vd);
            if (vecs[r].e_vd) begin
                chk($sformatf("vec%0d_tdata", r), bus.tag_data, vecs[r].e_tdata);
                chk($sformatf("vec%0d_rdata", r), bus.read_data, CDATA);
            end
            chk($sformatf("vec%0d_perr", r), bus.protocol_err, vecs[r].e_perr);
        end
        zero_inputs();

        // ---- fill all 8 tags, 9th stalls, completions 3 then 1 with held return
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.valid_tran = 1'b1; bus.addr = 32'(i * 'h10);
            step();
            chk("fill_ack", bus.ack_tran, 1);
            chk("fill_tag", bus.tag_tran, i);
            bus.valid_tran = 1'b0;
            step();
        end
        chk("fill_full", bus.full, 1);
        bus.valid_tran = 1'b1; bus.addr = 32'h900;
        repeat (4) begin
            step();
            chk("ninth_noack", bus.ack_tran, 0);
        end
        bus.issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_tag", bus.issue_tag, i);
            step();
        end
        bus.issue_ready = 1'b0;
        chk("drain_empty", bus.issue_valid, 0);
        chk("drain_full", bus.full, 1);
        bus.cpl_valid = 1'b1; bus.cpl_tag = 3'd3; bus.cpl_data = D3;
        step();
        chk("c3_vd", bus.valid_data, 1);
        chk("c3_tag", bus.tag_data, 3);
        chk("c3_cr", bus.cpl_ready, 0);
        bus.cpl_tag = 3'd1; bus.cpl_data = D1;
        repeat (5) begin
            step();
            chk("hold_vd", bus.valid_data, 1);
            chk("hold_tag", bus.tag_data, 3);
            chk("hold_data", bus.read_data, D3);
            chk("hold_cr", bus.cpl_ready, 0);
            chk("hold_noack", bus.ack_tran, 0);
        end
        bus.ack_data = 1'b1;
        step();
        bus.ack_data = 1'b0;
        chk("ack3_vd", bus.valid_data, 0);
        chk("ack3_cr", bus.cpl_ready, 1);
        chk("ack3_full", bus.full, 0);
        chk("ack3_noack", bus.ack_tran, 0);
        step();
        chk("ninth_ack", bus.ack_tran, 1);
        chk("ninth_tag", bus.tag_tran, 3);
        chk("c1_vd", bus.valid_data, 1);
        chk("c1_tag", bus.tag_data, 1);
        chk("c1_data", bus.read_data, D1);
        zero_inputs();
        step();

        // ---- reset with 4 tags outstanding and a return pending
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.valid_tran = 1'b1; bus.addr = 32'h1000 + 32'(i);
            step();
            bus.valid_tran = 1'b0;
            step();
        end
        bus.issue_ready = 1'b1;
        repeat (4) step();
        bus.issue_ready = 1'b0;
        bus.cpl_valid = 1'b1; bus.cpl_tag = 3'd0; bus.cpl_data = D3;
        step();
        bus.cpl_valid = 1'b0;
        chk("prerst_vd", bus.valid_data, 1);
        bus.valid_tran = 1'b1; bus.addr = 32'h2000;
        reset = 1'b0;
        step();
        chk_reset_outputs("midrst");
        bus.valid_tran = 1'b0;
        reset = 1'b1;
        step();
        chk("postrst_ack", bus.ack_tran, 0);
        chk("postrst_vd", bus.valid_data, 0);
        bus.valid_tran = 1'b1;
        step();
        chk("postrst_ack2", bus.ack_tran, 1);
        chk("postrst_tag", bus.tag_tran, 0);
        zero_inputs();
        step();

        // ---- randomized traffic against the reference model
        do_reset();
        q.delete();
        for (int i = 0; i < 8; i++) begin busy[i] = 0; waiting[i] = 0; end
        m_ack = 0; m_rv = 0; m_perr = 0; m_ack_tag = '0; m_rtag = '0; m_rdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int nb;
            int wl[$];
            bit acc, popv, cacc, rack, legal;
            logic [2:0] ltag;
            ent_t e;
            nb = 0;
            for (int i = 0; i < 8; i++) nb += busy[i];
            chk("rnd_ack", bus.ack_tran, m_ack);
            if (m_ack) chk("rnd_tag", bus.tag_tran, m_ack_tag);
            chk("rnd_full", bus.full, nb == 8);
            chk("rnd_iv", bus.issue_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("rnd_iaddr", bus.issue_addr, q[0].addr);
                chk("rnd_idata", bus.issue_data, q[0].data);
                chk("rnd_irw", bus.issue_rw, q[0].rw);
                chk("rnd_itag", bus.issue_tag, q[0].tag);
            end
            chk("rnd_vd", bus.valid_data, m_rv);
            chk("rnd_cr", bus.cpl_ready, !m_rv);
            if (m_rv) begin
                chk("rnd_tdata", bus.tag_data, m_rtag);
                chk("rnd_rdata", bus.read_data, m_rdata);
            end
            chk("rnd_perr", bus.protocol_err, m_perr);

            // cache holds a request until ack, then drops it for a cycle
            if (bus.valid_tran && m_ack) bus.valid_tran = 1'b0;
            else if (!bus.valid_tran && $urandom_range(0, 1) == 1) begin
                bus.valid_tran = 1'b1; bus.addr = $urandom;
                bus.rw = ($urandom_range(0, 2) == 0); bus.data_tran = rnd512();
            end
            bus.issue_ready = (cyc < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 8; i++) if (waiting[i]) wl.push_back(i);
            bus.cpl_valid = ($urandom_range(0, 2) == 0);
            if (wl.size() != 0 && $urandom_range(0, 7) != 0)
                bus.cpl_tag = 3'(wl[$urandom_range(0, wl.size() - 1)]);
            else
                bus.cpl_tag = 3'($urandom_range(0, 7));
            bus.cpl_data = rnd512();
            bus.ack_data = ($urandom_range(0, 1) == 1);

            @(posedge clock);
            acc   = bus.valid_tran && (nb != 8) && !m_ack;
            ltag  = '0;
            for (int i = 7; i >= 0; i--) if (!busy[i]) ltag = 3'(i);
            popv  = (q.size() != 0) && bus.issue_ready;
            cacc  = bus.cpl_valid && !m_rv;
            legal = waiting[bus.cpl_tag];
            rack  = bus.ack_data && m_rv;
            if (popv) begin
                e = q.pop_front();
                if (e.rw) busy[e.tag] = 0; else waiting[e.tag] = 1;
            end
            if (acc) begin
                busy[ltag] = 1;
                q.push_back('{bus.addr, bus.data_tran, bus.rw, ltag});
            end
            m_perr = cacc && !legal;
            if (cacc && legal) begin
                waiting[bus.cpl_tag] = 0; m_rv = 1; m_rtag = bus.cpl_tag; m_rdata = bus.cpl_data;
            end else if (rack) begin
                m_rv = 0; busy[m_rtag] = 0;
            end
            m_ack = acc;
            if (acc) m_ack_tag = ltag;
            @(negedge clock);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mc_txn_scheduler.md
# mc_txn_scheduler

Front end of the DDR4 memory controller: accepts cache transactions on the memory side of the cache-to-memory link, allocates 3-bit tags and acknowledges them, then queues and issues them in arrival order to the DRAM command engine. Read completions from the engine return to the cache with their tags through a held valid/ack handshake. Each tag is tracked by a per-tag state machine, and `full` is asserted when no tag is free.

## Interface
Parameters:
- DWIDTH, 512, data width of transaction and read data
- AWIDTH, 32, address width
- NTAGS, 8, tag count and queue depth; fixed by the 3-bit tag, not overridable

Ports:
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-low; clears all state
- addr  in  AWIDTH  transaction address
- data_tran  in  DWIDTH  write data; ignored for reads
- rw  in  1  1 = write, 0 = read
- valid_tran  in  1  request; held by cache until ack_tran
- ack_tran  out  1  one-cycle acceptance pulse
- tag_tran  out  3  tag of accepted transaction; valid with ack_tran
- full  out  1  no free tag; no acceptance this cycle
- issue_valid  out  1  queue head valid to command engine
- issue_ready  in  1  engine accepts head
- issue_addr  out  AWIDTH  head address
- issue_data  out  DWIDTH  head write data
- issue_rw  out  1  head direction
- issue_tag  out  3  head tag
- cpl_valid  in  1  engine read completion
- cpl_tag  in  3  completion tag
- cpl_data  in  DWIDTH  completion data
- cpl_ready  out  1  return register empty, completion accepted
- read_data  out  DWIDTH  returned read data
- tag_data  out  3  returned tag
- valid_data  out  1  return valid; held until ack_data
- ack_data  in  1  cache consumed return
- protocol_err  out  1  one-cycle pulse on illegal completion

## Operation
- Per-tag FSM: FREE -> QUEUED (accept) -> write: FREE on issue handshake; read: WAIT_DATA on issue handshake -> RETURN on completion accept -> FREE on ack_data.
- Accept condition: valid_tran & !full & !ack_tran at edge. Allocated tag is the lowest-numbered FREE tag from pre-edge state. {addr, data_tran, rw, tag} are pushed to the issue FIFO.
- Issue FIFO: NTAGS entries, arrival order, no reordering. issue_* reflect the head. Pop on issue_valid & issue_ready.
- Completion: accepted when cpl_valid & cpl_ready. Loads read_data/tag_data and sets valid_data.
- Completion with a tag not in WAIT_DATA: accepted and discarded, protocol_err pulses next cycle, tag state unchanged.
- Return: valid_data, read_data, tag_data stay stable until ack_data. ack_data while valid_data = 0 is ignored.
- full = no tag in FREE. Registered from next-state, so it is accurate the cycle after any allocate or free.

## Timing
- Reset (reset = 0 at edge): all tags FREE, FIFO empty. ack_tran, tag_tran, issue_valid, valid_data, protocol_err, full = 0; cpl_ready = 1; data outputs 0.
- Reset mid-operation discards all outstanding transactions and return data. No ack_tran or valid_data follows.
- Accept at edge N -> ack_tran = 1 and tag_tran valid during cycle N+1. The cache drops or changes valid_tran in N+1, so peak acceptance is one transaction per 2 cycles.
- Accept at edge N -> issue_valid no earlier than cycle N+1 if the FIFO was empty.
- cpl_ready = !valid_data (registered). Completion at edge N -> valid_data in N+1. ack_data at edge M -> valid_data = 0 and cpl_ready = 1 in M+1, tag FREE in M+1.
- Simultaneous accept and free at one edge: the freed tag is not allocatable at that edge. Count is net of both.
- Simultaneous FIFO push and pop: occupancy unchanged. A push into an empty FIFO is not visible at the head the same edge.
- Write freed at issue edge N -> full may drop in N+1.

## Structure
- Package mc_pkg: NTAGS, TAG_W = 3, tag_state_t enum {FREE, QUEUED, WAIT_DATA, RETURN}, issue entry struct {addr, data, rw, tag}.
- Sub-module mc_tag_fifo: parameterised synchronous FIFO (depth NTAGS, entry struct), with push/pop/empty/count.
- Top holds the tag FSM array, lowest-free priority encoder, return register and error pulse.

## Test plan
- Reset, then read addr 0x100: ack_tran with tag 0 one cycle after accept. Issue with issue_rw = 0, tag 0. Completion data 0xA5.. appears on read_data with tag_data = 0. ack_data frees tag 0.
- 8 reads with issue_ready = 0: tags 0..7 in order, full = 1 after the 8th. A 9th valid_tran gets no ack until one read completes and is acked.
- Write at addr 0x40 with issue_ready = 1: tag freed on issue, no valid_data ever. Next request reuses tag 0.
- Completions for tags 3 then 1 while valid_data is held 5 cycles: cpl_ready = 0 stalls tag 1. Returns appear in completion order with data intact.
- Completion with cpl_tag = 5 while tag 5 is FREE: protocol_err pulses once, no valid_data.
- Assert reset with 4 tags outstanding and valid_data = 1: next cycle all outputs are at reset values, and full = 0.
